// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// Contents:
//   XLEN_DEFAULT, NUM_SRC_DEFAULT : default datapath width and number of result sources
//   SRC_*                         : source indices; lower index means higher priority
//   wb_entry_t                    : layout of one late-result entry at the default width
package wb_pkg;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned NUM_SRC_DEFAULT = 5;

    localparam int unsigned SRC_MEM = 0;
    localparam int unsigned SRC_CSR = 1;
    localparam int unsigned SRC_MUL = 2;
    localparam int unsigned SRC_DIV = 3;
    localparam int unsigned SRC_ALU = 4;

    typedef struct packed {
        logic [4:0]              rd;
        logic [XLEN_DEFAULT-1:0] data;
        logic                    live;
    } wb_entry_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Late-result queue for the writeback stage.
// Holds results from multi-cycle units until the register-file port is idle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_rd/data  : enqueue request (caller guarantees !full)
//   pop                 : drop the head entry (caller guarantees head_valid)
//   kill, kill_rd       : mark every entry targeting kill_rd dead (WAW against a younger write)
//   full                : no free slot
//   head_valid          : at least one entry is queued
//   head_live           : head entry still needs to be written
//   head_rd, head_data  : head entry contents
//   pending             : one-hot OR of the rd of all live entries (bit 0 always 0)
module wb_late_fifo
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [4:0]      push_rd,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    input  logic            kill,
    input  logic [4:0]      kill_rd,
    output logic            full,
    output logic            head_valid,
    output logic            head_live,
    output logic [4:0]      head_rd,
    output logic [XLEN-1:0] head_data,
    output logic [31:0]     pending
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    // Storage needs no reset: liveness and count decide what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= push_rd;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (kill && (rd_q[i] == kill_rd)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                // rd=0 is stored dead; a same-cycle kill also beats the older late result.
                live_q[wr_ptr_q] <= (push_rd != 5'd0) && !(kill && (push_rd == kill_rd));
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_comb begin
        full       = (count_q == CntW'(DEPTH));
        head_valid = (count_q != '0);
        head_live  = head_valid && live_q[rd_ptr_q];
        head_rd    = rd_q[rd_ptr_q];
        head_data  = data_q[rd_ptr_q];
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (live_q[i]) begin
                pending[rd_q[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects the MEM/WB result, arbitrates the register-file write port
// between the pipeline and queued late results, and keeps a short history of committed
// writes for ID-stage forwarding.
// Ports:
//   clk, Rst                      : clock, synchronous active-high reset
//   dbg, mem_hold                 : freeze inputs (no drain, no kill, history holds)
//   MEM_WB_rd/regwrite            : pipeline destination and write enable
//   MEM_WB_src_sel/src_data       : one-hot source select and packed source results
//   late_valid/rd/data, late_ready: late-result enqueue handshake
//   WB_res/WB_rd/WB_regwrite      : register-file write port (combinational)
//   rd_pending                    : registers targeted by live queued late results
//   WB_ID_rd/res/regwrite         : committed-write history, entry 0 newest
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned NUM_SRC    = NUM_SRC_DEFAULT,
    parameter int unsigned LATE_DEPTH = 4,
    parameter int unsigned FWD_DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      Rst,
    input  logic                      dbg,
    input  logic                      mem_hold,
    input  logic [4:0]                MEM_WB_rd,
    input  logic                      MEM_WB_regwrite,
    input  logic [NUM_SRC-1:0]        MEM_WB_src_sel,
    input  logic [NUM_SRC*XLEN-1:0]   MEM_WB_src_data,
    input  logic                      late_valid,
    input  logic [4:0]                late_rd,
    input  logic [XLEN-1:0]           late_data,
    output logic                      late_ready,
    output logic [XLEN-1:0]           WB_res,
    output logic [4:0]                WB_rd,
    output logic                      WB_regwrite,
    output logic [31:0]               rd_pending,
    output logic [FWD_DEPTH*5-1:0]    WB_ID_rd,
    output logic [FWD_DEPTH*XLEN-1:0] WB_ID_res,
    output logic [FWD_DEPTH-1:0]      WB_ID_regwrite
);

    logic            freeze;
    logic            pipe_wr;
    logic            drain;
    logic            fifo_full;
    logic            head_valid;
    logic            head_live;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [XLEN-1:0] sel_data;
    logic            sel_found;

    logic [4:0]      hist_rd_q  [FWD_DEPTH];
    logic [XLEN-1:0] hist_res_q [FWD_DEPTH];
    logic [FWD_DEPTH-1:0] hist_wr_q;

    assign freeze  = dbg | mem_hold;
    assign pipe_wr = MEM_WB_regwrite && (MEM_WB_rd != 5'd0);
    // Head leaves the queue on any unfrozen cycle the pipeline leaves the port free;
    // a dead head leaves without producing a write.
    assign drain   = !pipe_wr && !freeze && head_valid;

    // Lowest set select bit wins; with no bit set the last source (ALU) is the default.
    always_comb begin
        sel_data  = MEM_WB_src_data[(NUM_SRC-1)*XLEN +: XLEN];
        sel_found = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (!sel_found && MEM_WB_src_sel[i]) begin
                sel_data  = MEM_WB_src_data[i*XLEN +: XLEN];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        WB_regwrite = 1'b0;
        WB_rd       = 5'd0;
        WB_res      = '0;
        if (pipe_wr) begin
            WB_regwrite = 1'b1;
            WB_rd       = MEM_WB_rd;
            WB_res      = sel_data;
        end else if (drain && head_live) begin
            WB_regwrite = 1'b1;
            WB_rd       = head_rd;
            WB_res      = head_data;
        end
    end

    assign late_ready = !fifo_full;

    wb_late_fifo #(
        .XLEN  (XLEN),
        .DEPTH (LATE_DEPTH)
    ) u_late_fifo (
        .clk        (clk),
        .rst        (Rst),
        .push       (late_valid && !fifo_full),
        .push_rd    (late_rd),
        .push_data  (late_data),
        .pop        (drain),
        .kill       (pipe_wr && !freeze),
        .kill_rd    (MEM_WB_rd),
        .full       (fifo_full),
        .head_valid (head_valid),
        .head_live  (head_live),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .pending    (rd_pending)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                hist_rd_q[k]  <= 5'd0;
                hist_res_q[k] <= '0;
            end
            hist_wr_q <= '0;
        end else if (!freeze) begin
            for (int k = 1; k < int'(FWD_DEPTH); k++) begin
                hist_rd_q[k]  <= hist_rd_q[k-1];
                hist_res_q[k] <= hist_res_q[k-1];
                hist_wr_q[k]  <= hist_wr_q[k-1];
            end
            hist_rd_q[0]  <= WB_rd;
            hist_res_q[0] <= WB_res;
            hist_wr_q[0]  <= WB_regwrite;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(FWD_DEPTH); k++) begin
            WB_ID_rd[k*5 +: 5]       = hist_rd_q[k];
            WB_ID_res[k*XLEN +: XLEN] = hist_res_q[k];
        end
        WB_ID_regwrite = hist_wr_q;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (default parameters).
module tb_writeback_unit;

    logic         clk = 1'b0;
    logic         Rst;
    logic         dbg;
    logic         mem_hold;
    logic [4:0]   MEM_WB_rd;
    logic         MEM_WB_regwrite;
    logic [4:0]   MEM_WB_src_sel;
    logic [159:0] MEM_WB_src_data;
    logic         late_valid;
    logic [4:0]   late_rd;
    logic [31:0]  late_data;
    logic         late_ready;
    logic [31:0]  WB_res;
    logic [4:0]   WB_rd;
    logic         WB_regwrite;
    logic [31:0]  rd_pending;
    logic [9:0]   WB_ID_rd;
    logic [63:0]  WB_ID_res;
    logic [1:0]   WB_ID_regwrite;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk             (clk),
        .Rst             (Rst),
        .dbg             (dbg),
        .mem_hold        (mem_hold),
        .MEM_WB_rd       (MEM_WB_rd),
        .MEM_WB_regwrite (MEM_WB_regwrite),
        .MEM_WB_src_sel  (MEM_WB_src_sel),
        .MEM_WB_src_data (MEM_WB_src_data),
        .late_valid      (late_valid),
        .late_rd         (late_rd),
        .late_data       (late_data),
        .late_ready      (late_ready),
        .WB_res          (WB_res),
        .WB_rd           (WB_rd),
        .WB_regwrite     (WB_regwrite),
        .rd_pending      (rd_pending),
        .WB_ID_rd        (WB_ID_rd),
        .WB_ID_res       (WB_ID_res),
        .WB_ID_regwrite  (WB_ID_regwrite)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dbg             = 1'b0;
        mem_hold        = 1'b0;
        MEM_WB_rd       = 5'd0;
        MEM_WB_regwrite = 1'b0;
        MEM_WB_src_sel  = 5'd0;
        MEM_WB_src_data = '0;
        late_valid      = 1'b0;
        late_rd         = 5'd0;
        late_data       = 32'd0;
    endtask

    // Pipeline write through the default (ALU) source.
    task automatic pipe_write(input logic [4:0] rd, input logic [31:0] data);
        MEM_WB_regwrite         = 1'b1;
        MEM_WB_rd               = rd;
        MEM_WB_src_sel          = 5'd0;
        MEM_WB_src_data         = '0;
        MEM_WB_src_data[128 +: 32] = data;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
        #1;
        nvec++; if (late_ready !== 1'b1) begin nfail++;
            $display("FAIL reset_late_ready: got %b expected 1", late_ready); end
        nvec++; if (rd_pending !== 32'd0) begin nfail++;
            $display("FAIL reset_pending: got %h expected 0", rd_pending); end
        nvec++; if (WB_ID_regwrite !== 2'b00 || WB_ID_rd !== 10'd0 || WB_ID_res !== 64'd0) begin
            nfail++;
            $display("FAIL reset_history: got wr=%b rd=%h res=%h expected all 0",
                     WB_ID_regwrite, WB_ID_rd, WB_ID_res); end
        nvec++; if (WB_regwrite !== 1'b0) begin nfail++;
            $display("FAIL reset_port: got %b expected 0", WB_regwrite); end
    endtask

    task automatic test_src_select();
        MEM_WB_regwrite         = 1'b1;
        MEM_WB_rd               = 5'd7;
        MEM_WB_src_sel          = 5'b00110;
        MEM_WB_src_data[0 +: 32]   = 32'hDEAD;
        MEM_WB_src_data[32 +: 32]  = 32'h11;
        MEM_WB_src_data[64 +: 32]  = 32'h22;
        MEM_WB_src_data[96 +: 32]  = 32'h33;
        MEM_WB_src_data[128 +: 32] = 32'hAAAA;
        #1;
        nvec++; if (WB_res !== 32'h11 || WB_rd !== 5'd7 || WB_regwrite !== 1'b1) begin nfail++;
            $display("FAIL src_sel_port: got res=%h rd=%0d wr=%b expected 11/7/1",
                     WB_res, WB_rd, WB_regwrite); end
        step();
        MEM_WB_rd      = 5'd8;
        MEM_WB_src_sel = 5'b10000;
        #1;
        nvec++; if (WB_ID_rd[4:0] !== 5'd7 || WB_ID_res[31:0] !== 32'h11
                    || WB_ID_regwrite[0] !== 1'b1) begin nfail++;
            $display("FAIL src_sel_hist0: got rd=%0d res=%h wr=%b expected 7/11/1",
                     WB_ID_rd[4:0], WB_ID_res[31:0], WB_ID_regwrite[0]); end
        nvec++; if (WB_res !== 32'hAAAA) begin nfail++;
            $display("FAIL src_sel_top: got %h expected aaaa", WB_res); end
        step();
        MEM_WB_src_sel = 5'b01000;
        #1;
        nvec++; if (WB_res !== 32'h33) begin nfail++;
            $display("FAIL src_sel_bit3: got %h expected 33", WB_res); end
        nvec++; if (WB_ID_rd !== {5'd7, 5'd8} || WB_ID_res[63:32] !== 32'h11) begin nfail++;
            $display("FAIL src_sel_shift: got rd=%h res1=%h expected %h/11",
                     WB_ID_rd, WB_ID_res[63:32], {5'd7, 5'd8}); end
        MEM_WB_src_sel = 5'b11111;
        #1;
        nvec++; if (WB_res !== 32'hDEAD) begin nfail++;
            $display("FAIL src_sel_all: got %h expected dead", WB_res); end
        step();
        idle_inputs();
    endtask

    task automatic test_default_src();
        pipe_write(5'd3, 32'hABCD);
        #1;
        nvec++; if (WB_res !== 32'hABCD || WB_rd !== 5'd3 || WB_regwrite !== 1'b1) begin nfail++;
            $display("FAIL default_src: got res=%h rd=%0d wr=%b expected abcd/3/1",
                     WB_res, WB_rd, WB_regwrite); end
        MEM_WB_rd = 5'd0;
        #1;
        nvec++; if (WB_regwrite !== 1'b0 || WB_rd !== 5'd0 || WB_res !== 32'd0) begin nfail++;
            $display("FAIL default_rd0: got wr=%b rd=%0d res=%h expected 0/0/0",
                     WB_regwrite, WB_rd, WB_res); end
        step();
        idle_inputs();
    endtask

    task automatic test_late_drain();
        pipe_write(5'd4, 32'h44);
        late_valid = 1'b1;
        late_rd    = 5'd9;
        late_data  = 32'h55;
        #1;
        nvec++; if (WB_rd !== 5'd4 || WB_res !== 32'h44 || late_ready !== 1'b1) begin nfail++;
            $display("FAIL drain_pipe_wins: got rd=%0d res=%h rdy=%b expected 4/44/1",
                     WB_rd, WB_res, late_ready); end
        step();
        late_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            nvec++; if (rd_pending[9] !== 1'b1 || WB_rd !== 5'd4) begin nfail++;
                $display("FAIL drain_wait%0d: got pend9=%b rd=%0d expected 1/4",
                         c, rd_pending[9], WB_rd); end
            step();
        end
        idle_inputs();
        #1;
        nvec++; if (WB_regwrite !== 1'b1 || WB_rd !== 5'd9 || WB_res !== 32'h55) begin nfail++;
            $display("FAIL drain_write: got wr=%b rd=%0d res=%h expected 1/9/55",
                     WB_regwrite, WB_rd, WB_res); end
        step();
        nvec++; if (rd_pending !== 32'd0 || WB_regwrite !== 1'b0) begin nfail++;
            $display("FAIL drain_done: got pend=%h wr=%b expected 0/0",
                     rd_pending, WB_regwrite); end
    endtask

    task automatic test_waw_kill();
        late_valid = 1'b1;
        late_rd    = 5'd9;
        late_data  = 32'h55;
        #1;
        nvec++; if (WB_regwrite !== 1'b0) begin nfail++;
            $display("FAIL waw_no_bypass: got wr=%b expected 0", WB_regwrite); end
        step();
        late_valid = 1'b0;
        pipe_write(5'd9, 32'h77);
        #1;
        nvec++; if (WB_res !== 32'h77 || WB_rd !== 5'd9 || rd_pending[9] !== 1'b1) begin nfail++;
            $display("FAIL waw_pipe: got res=%h rd=%0d pend9=%b expected 77/9/1",
                     WB_res, WB_rd, rd_pending[9]); end
        step();
        idle_inputs();
        #1;
        nvec++; if (rd_pending !== 32'd0 || WB_regwrite !== 1'b0) begin nfail++;
            $display("FAIL waw_killed: got pend=%h wr=%b res=%h expected 0/0",
                     rd_pending, WB_regwrite, WB_res); end
        step();
        nvec++; if (WB_regwrite !== 1'b0) begin nfail++;
            $display("FAIL waw_after: got wr=%b res=%h expected 0", WB_regwrite, WB_res); end
        // Kill of an entry enqueued in the same cycle.
        pipe_write(5'd12, 32'h3);
        late_valid = 1'b1;
        late_rd    = 5'd12;
        late_data  = 32'h1212;
        step();
        idle_inputs();
        #1;
        nvec++; if (rd_pending !== 32'd0 || WB_regwrite !== 1'b0) begin nfail++;
            $display("FAIL waw_same_cycle: got pend=%h wr=%b expected 0/0",
                     rd_pending, WB_regwrite); end
        step();
    endtask

    task automatic test_full_freeze();
        for (int i = 1; i <= 4; i++) begin
            pipe_write(5'd20, 32'h2020);
            late_valid = 1'b1;
            late_rd    = 5'(i);
            late_data  = 32'h100 + 32'(i);
            #1;
            nvec++; if (late_ready !== 1'b1) begin nfail++;
                $display("FAIL fill_ready%0d: got %b expected 1", i, late_ready); end
            step();
        end
        idle_inputs();
        mem_hold = 1'b1;
        #1;
        nvec++; if (late_ready !== 1'b0 || WB_regwrite !== 1'b0 || rd_pending !== 32'h1E) begin
            nfail++;
            $display("FAIL full_frozen: got rdy=%b wr=%b pend=%h expected 0/0/0000001e",
                     late_ready, WB_regwrite, rd_pending); end
        step();
        nvec++; if (WB_ID_rd[4:0] !== 5'd20 || WB_regwrite !== 1'b0 || rd_pending !== 32'h1E) begin
            nfail++;
            $display("FAIL freeze_hold: got hist_rd=%0d wr=%b pend=%h expected 20/0/0000001e",
                     WB_ID_rd[4:0], WB_regwrite, rd_pending); end
        step();
        mem_hold   = 1'b0;
        late_valid = 1'b1;  // offered while full: must not be taken despite the pop
        late_rd    = 5'd6;
        late_data  = 32'h666;
        #1;
        nvec++; if (WB_rd !== 5'd1 || WB_res !== 32'h101 || late_ready !== 1'b0) begin nfail++;
            $display("FAIL pop1: got rd=%0d res=%h rdy=%b expected 1/101/0",
                     WB_rd, WB_res, late_ready); end
        step();
        late_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            #1;
            nvec++; if (WB_regwrite !== 1'b1 || WB_rd !== 5'(i) || WB_res !== 32'h100 + 32'(i)
                        || late_ready !== 1'b1) begin nfail++;
                $display("FAIL pop%0d: got wr=%b rd=%0d res=%h rdy=%b expected 1/%0d/%h/1",
                         i, WB_regwrite, WB_rd, WB_res, late_ready, i, 32'h100 + 32'(i)); end
            step();
        end
        nvec++; if (WB_regwrite !== 1'b0 || rd_pending !== 32'd0) begin nfail++;
            $display("FAIL full_empty: got wr=%b rd=%0d pend=%h expected 0/0",
                     WB_regwrite, WB_rd, rd_pending); end
    endtask

    task automatic test_reset_midop();
        pipe_write(5'd15, 32'hF0);
        step();
        idle_inputs();
        dbg        = 1'b1;
        late_valid = 1'b1;
        late_rd    = 5'd10;
        late_data  = 32'hA0;
        step();
        late_rd    = 5'd11;
        late_data  = 32'hB0;
        step();
        late_valid = 1'b0;
        #1;
        nvec++; if (rd_pending !== 32'h0C00 || WB_ID_rd[4:0] !== 5'd15 || WB_regwrite !== 1'b0)
        begin nfail++;
            $display("FAIL midop_state: got pend=%h hist_rd=%0d wr=%b expected 00000c00/15/0",
                     rd_pending, WB_ID_rd[4:0], WB_regwrite); end
        dbg = 1'b0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        #1;
        nvec++; if (late_ready !== 1'b1 || rd_pending !== 32'd0) begin nfail++;
            $display("FAIL midop_reset_fifo: got rdy=%b pend=%h expected 1/0",
                     late_ready, rd_pending); end
        nvec++; if (WB_ID_rd !== 10'd0 || WB_ID_res !== 64'd0 || WB_ID_regwrite !== 2'b00) begin
            nfail++;
            $display("FAIL midop_reset_hist: got rd=%h res=%h wr=%b expected 0",
                     WB_ID_rd, WB_ID_res, WB_ID_regwrite); end
        for (int c = 0; c < 3; c++) begin
            nvec++; if (WB_regwrite !== 1'b0) begin nfail++;
                $display("FAIL midop_no_late%0d: got wr=%b rd=%0d expected 0",
                         c, WB_regwrite, WB_rd); end
            step();
        end
    endtask

    initial begin
        Rst = 1'b1;
        idle_inputs();
        test_reset();
        test_src_select();
        test_default_src();
        test_late_drain();
        test_waw_kill();
        test_full_freeze();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Parametrised writeback stage for the Mini-RISC-V pipeline. It selects the MEM/WB result from NUM_SRC prioritised sources and drives the single register-file write port. Late results from multi-cycle units are queued in a small FIFO and drained into idle write slots, with WAW kills against younger pipeline writes. A FWD_DEPTH-deep history of committed writes feeds ID-stage forwarding.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 5, result sources; index 0 is highest priority, index NUM_SRC-1 is the default (ALU)
LATE_DEPTH, 4, late-result FIFO entries (power of 2, >=2)
FWD_DEPTH, 2, forwarding-history entries (>=1)

Ports:
clk  in  1  clock
Rst  in  1  synchronous active-high reset
dbg  in  1  debug freeze
mem_hold  in  1  memory stall freeze
MEM_WB_rd  in  5  destination register of the pipeline instruction
MEM_WB_regwrite  in  1  pipeline instruction writes rd
MEM_WB_src_sel  in  NUM_SRC  one-hot source select (may be zero)
MEM_WB_src_data  in  NUM_SRC*XLEN  packed source results; slice i is source i
late_valid  in  1  late result offered
late_rd  in  5  late destination register
late_data  in  XLEN  late result value
late_ready  out  1  FIFO can accept
WB_res  out  XLEN  register-file write data (combinational)
WB_rd  out  5  register-file write address (combinational)
WB_regwrite  out  1  register-file write enable (combinational)
rd_pending  out  32  bit r set while any live FIFO entry targets r
WB_ID_rd  out  FWD_DEPTH*5  history rd; entry 0 is newest
WB_ID_res  out  FWD_DEPTH*XLEN  history data
WB_ID_regwrite  out  FWD_DEPTH  history write flags

Behaviour:
- Definitions: freeze = dbg | mem_hold. pipe_wr = MEM_WB_regwrite & (MEM_WB_rd != 0).
- Source select: the lowest set bit of MEM_WB_src_sel wins. If no bit is set, source NUM_SRC-1 is used. The choice is purely combinational.
- Write-port arbitration, combinational:
  - If pipe_wr: the port takes the pipeline rd and the selected data.
  - Else if the FIFO head is live and freeze=0: the port takes the head entry, and the head pops at the clock edge.
  - Else: WB_regwrite=0, WB_rd=0, WB_res=0.
  - The pipeline always wins the port; late data waits with no fixed bound.
- Late FIFO:
  - Enqueue when late_valid & late_ready. late_ready = !full.
  - Enqueue is allowed during freeze.
  - late_rd=0 is accepted and stored as a dead entry.
  - Enqueue and pop may occur in the same cycle; when full, a same-cycle pop does not raise late_ready (no bypass).
- WAW kill: on any cycle with pipe_wr and freeze=0, every FIFO entry whose rd equals MEM_WB_rd is marked dead. This includes an entry enqueued in the same cycle, because the late result is older.
- Dead entries: a dead entry at the head pops silently on any freeze=0 cycle when the port is not used by the pipeline. A dead pop produces no write.
- rd_pending is the OR of the one-hot decodes of all live entries. Bit 0 is always 0.
- History, registered:
  - When freeze=0: entries shift by one (entry k takes entry k-1), and entry 0 takes {WB_rd, WB_res, WB_regwrite} from this cycle.
  - When freeze=1: history holds.
- Reset, synchronous: FIFO empty, all entries dead, pointers 0. All history fields 0. late_ready=1. rd_pending=0.
- Reset takes priority over every other event. Queued late results are lost; the issuing unit must also be reset.
- Latency: pipeline write is 0 cycles to the port and 1 cycle to history entry 0. An enqueued late result reaches the port no earlier than the next cycle.

Decomposition:
- Package wb_pkg: source index constants (SRC_MEM=0, SRC_CSR=1, SRC_MUL=2, SRC_DIV=3, SRC_ALU=4), NUM_SRC_DEFAULT, and the typedef wb_entry_t {rd[4:0], data[XLEN-1:0], live}.
- Sub-module: wb_late_fifo. It holds storage, pointers, count, the kill-match compare, the pending-mask OR and head output. The top level keeps source select, arbitration and history.

Test Plan:
- Src select: sel=5'b00110, slice1=0x11, slice2=0x22, regwrite=1, rd=7 -> WB_res=0x11, WB_rd=7; next cycle WB_ID_rd[0]=7, WB_ID_res[0]=0x11.
- Default src: sel=0, slice4=0xABCD, rd=3 -> WB_res=0xABCD. With rd=0 and regwrite=1 -> WB_regwrite=0.
- Late drain: enqueue rd=9 data=0x55 with the pipeline busy writing rd=4 for 3 cycles -> rd_pending[9]=1 throughout. First idle cycle -> WB_rd=9, WB_res=0x55; the next cycle rd_pending=0.
- WAW kill: queued rd=9, then a pipeline write to rd=9 with 0x77 -> port writes 0x77, the FIFO entry dies, rd_pending[9] clears, and 0x55 is never written.
- Full/freeze: fill 4 entries -> late_ready=0. Assert mem_hold with the pipeline idle -> no pops, history frozen. Deassert -> pop one per cycle, and late_ready=1 one cycle after the first pop.
- Reset mid-op: 2 queued entries plus a valid history, then Rst=1 for one cycle -> late_ready=1, rd_pending=0, WB_ID_* all 0, and no late write ever appears.
